// File: rtl/pool_flat_pkg.sv
// Shared types and constants for the pool_flat max-pooling engine.
// The optional flatten output is enabled by defining POOL_FLAT_FLATTEN_EN.
package pool_flat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WRP,
        ST_WRF,
        ST_DONE
    } state_t;

    localparam logic [2:0] CSEL_NONE    = 3'd0;
    localparam logic [2:0] CSEL_IN_BASE = 3'd1;

    // Bits needed to index n items; never less than one.
    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_flat_max.sv
// Running signed-maximum register for one 2x2 pooling window.
module pool_flat_max
    import pool_flat_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_upd,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_max
);

    logic [DW-1:0] r_max;

    // Ties keep the stored value, so only a strictly larger datum replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max <= '0;
        end else if (i_load) begin
            r_max <= i_data;
        end else if (i_upd && ($signed(i_data) > $signed(r_max))) begin
            r_max <= i_data;
        end
    end

    assign o_max = r_max;

endmodule

// File: rtl/pool_flat.sv
// 2x2 stride-2 max pooling over CH maps, with optional flatten output
// when POOL_FLAT_FLATTEN_EN is defined.
//
// state   | meaning
// IDLE    | waiting for ready
// RD      | four window reads, one per cycle
// WAIT    | last read datum arrives
// WRP     | write pooled word for (p,c)
// WRF     | write flatten word for (p,c) (flatten build only)
// DONE    | one idle cycle with busy low before returning to IDLE
module pool_flat
    import pool_flat_pkg::*;
#(
    parameter int DW    = 20,
    parameter int IMG_W = 64,
    parameter int CH    = 2,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int HALF = IMG_W / 2;
    localparam int NPIX = HALF * HALF;
    localparam int LH   = $clog2(HALF);
    localparam int PW   = addr_bits(NPIX);
    localparam int CW   = addr_bits(CH);

    state_t          r_state;
    state_t          w_state_nx;
    logic [1:0]      r_rd_idx;
    logic [CW-1:0]   r_c;
    logic [PW-1:0]   r_p;
    logic            w_load;
    logic            w_upd;
    logic            w_adv;
    logic            w_last;
    logic [DW-1:0]   w_max;
    logic [AW-1:0]   w_rd_addr;
    logic [2:0]      w_c3;

    pool_flat_max #(.DW(DW)) u_max (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_upd  (w_upd),
        .i_data (cdata_rd),
        .o_max  (w_max)
    );

    // IMG_W is a power of two, so the window address is a bit concatenation.
    assign w_rd_addr = AW'({r_p[PW-1:LH], r_rd_idx[1], r_p[LH-1:0], r_rd_idx[0]});
    assign w_c3      = 3'(r_c);
    assign w_last    = (r_p == PW'(NPIX - 1)) && (r_c == CW'(CH - 1));
`ifdef POOL_FLAT_FLATTEN_EN
    assign w_adv     = (r_state == ST_WRF);
`else
    assign w_adv     = (r_state == ST_WRP);
`endif

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        crd        = 1'b0;
        cwr        = 1'b0;
        caddr_rd   = '0;
        caddr_wr   = '0;
        cdata_wr   = '0;
        csel       = CSEL_NONE;
        w_load     = 1'b0;
        w_upd      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ready) w_state_nx = ST_RD;
            end
            ST_RD: begin
                busy     = 1'b1;
                crd      = 1'b1;
                caddr_rd = w_rd_addr;
                csel     = CSEL_IN_BASE + w_c3;
                // Data lags its read by one cycle: load on the 2nd RD cycle.
                w_load   = (r_rd_idx == 2'd1);
                w_upd    = r_rd_idx[1];
                if (r_rd_idx == 2'd3) w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                busy       = 1'b1;
                w_upd      = 1'b1;
                w_state_nx = ST_WRP;
            end
            ST_WRP: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = CSEL_IN_BASE + 3'(CH) + w_c3;
                caddr_wr = AW'(r_p);
                cdata_wr = w_max;
`ifdef POOL_FLAT_FLATTEN_EN
                w_state_nx = ST_WRF;
`else
                w_state_nx = w_last ? ST_DONE : ST_RD;
`endif
            end
`ifdef POOL_FLAT_FLATTEN_EN
            ST_WRF: begin
                busy       = 1'b1;
                cwr        = 1'b1;
                csel       = CSEL_IN_BASE + 3'(2 * CH);
                caddr_wr   = AW'(int'(r_p) * CH + int'(r_c));
                cdata_wr   = w_max;
                w_state_nx = w_last ? ST_DONE : ST_RD;
            end
`endif
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rd_idx <= '0;
            r_c      <= '0;
            r_p      <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ST_RD) r_rd_idx <= r_rd_idx + 2'd1;
            if (w_adv) begin
                if (r_c == CW'(CH - 1)) begin
                    r_c <= '0;
                    r_p <= r_p + PW'(1);
                end else begin
                    r_c <= r_c + CW'(1);
                end
            end
            if (w_state_nx == ST_DONE) begin
                r_rd_idx <= '0;
                r_c      <= '0;
                r_p      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pool_flat.sv
// Self-checking bench for pool_flat: a 64x64x2 instance and a 4x4x1 instance.
module tb_pool_flat;

`ifdef POOL_FLAT_FLATTEN_EN
    localparam int  PER = 7;
    localparam bit  FL  = 1'b1;
`else
    localparam int  PER = 6;
    localparam bit  FL  = 1'b0;
`endif
    localparam int JOB_A = 1024 * 2 * PER;
    localparam int JOB_B = 4 * PER;

    typedef struct packed {
        logic [19:0] a, b, c, d;
        logic [19:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, ready_a, busy_a, crd_a, cwr_a;
    logic [11:0] caddr_rd_a, caddr_wr_a;
    logic [19:0] cdata_rd_a, cdata_wr_a;
    logic [2:0]  csel_a;
    logic        reset_b, ready_b, busy_b, crd_b, cwr_b;
    logic [11:0] caddr_rd_b, caddr_wr_b;
    logic [19:0] cdata_rd_b, cdata_wr_b;
    logic [2:0]  csel_b;

    pool_flat dut_a (
        .clk(clk), .reset(reset_a), .ready(ready_a), .busy(busy_a),
        .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a),
        .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a), .csel(csel_a)
    );

    pool_flat #(.DW(20), .IMG_W(4), .CH(1), .AW(12)) dut_b (
        .clk(clk), .reset(reset_b), .ready(ready_b), .busy(busy_b),
        .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b),
        .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b), .csel(csel_b)
    );

    logic [19:0] mem_a [2][4096];
    logic [19:0] pooled_a [2][1024];
    logic [19:0] flat_a [2048];
    logic [19:0] mem_b [16];
    logic [19:0] pooled_b [4];
    logic [19:0] flat_b [4];

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor-owned bookkeeping; the test process only reads these.
    logic        rq_a = 1'b0, rq_b = 1'b0, prev_a = 1'b0, prev_b = 1'b0;
    logic [11:0] rq_addr_a = '0, rq_addr_b = '0, first_addr_a = '0;
    logic [2:0]  rq_sel_a = '0, rq_sel_b = '0, first_sel_a = '0;
    int run_a = 0, last_run_a = 0, wr_pool_a = 0, wr_flat_a = 0, wr_bad_a = 0, overlap_a = 0;
    int run_b = 0, low_b = 0, starts_b = 0, falls_b = 0, last_run_b = 0;
    int wr_pool_b = 0, wr_flat_b = 0, wr_bad_b = 0, overlap_b = 0;
    int gaps_b [64];
    int runs_b [64];

    always @(negedge clk) begin
        rq_a = crd_a; rq_addr_a = caddr_rd_a; rq_sel_a = csel_a;
        if (crd_a && cwr_a) overlap_a++;
        if (busy_a) begin
            if (!prev_a) begin first_addr_a = caddr_rd_a; first_sel_a = csel_a; end
            run_a++;
        end else begin
            if (prev_a) last_run_a = run_a;
            run_a = 0;
        end
        prev_a = busy_a;
        if (cwr_a) begin
            if (csel_a == 3'd3 && caddr_wr_a < 12'd1024) begin
                pooled_a[0][caddr_wr_a[9:0]] = cdata_wr_a; wr_pool_a++;
            end else if (csel_a == 3'd4 && caddr_wr_a < 12'd1024) begin
                pooled_a[1][caddr_wr_a[9:0]] = cdata_wr_a; wr_pool_a++;
            end else if (csel_a == 3'd5 && caddr_wr_a < 12'd2048) begin
                flat_a[caddr_wr_a[10:0]] = cdata_wr_a; wr_flat_a++;
            end else wr_bad_a++;
        end
    end

    always @(negedge clk) begin
        rq_b = crd_b; rq_addr_b = caddr_rd_b; rq_sel_b = csel_b;
        if (crd_b && cwr_b) overlap_b++;
        if (busy_b) begin
            if (!prev_b) begin gaps_b[starts_b % 64] = low_b; starts_b++; end
            low_b = 0;
            run_b++;
        end else begin
            if (prev_b) begin runs_b[falls_b % 64] = run_b; falls_b++; last_run_b = run_b; end
            run_b = 0;
            low_b++;
        end
        prev_b = busy_b;
        if (cwr_b) begin
            if (csel_b == 3'd2 && caddr_wr_b < 12'd4) begin
                pooled_b[caddr_wr_b[1:0]] = cdata_wr_b; wr_pool_b++;
            end else if (csel_b == 3'd3 && caddr_wr_b < 12'd4) begin
                flat_b[caddr_wr_b[1:0]] = cdata_wr_b; wr_flat_b++;
            end else wr_bad_b++;
        end
    end

    // Layer memory: data for a read appears one cycle after the request.
    always @(posedge clk) begin
        cdata_rd_a <= !rq_a ? 20'h0 :
                      (rq_sel_a == 3'd2) ? mem_a[1][rq_addr_a] :
                      (rq_sel_a == 3'd1) ? mem_a[0][rq_addr_a] : 20'h0;
        cdata_rd_b <= (rq_b && rq_sel_b == 3'd1 && rq_addr_b < 12'd16) ?
                      mem_b[rq_addr_b[3:0]] : 20'h0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] ref_a(input int c, input int p);
        int orow, ocol;
        logic signed [19:0] m, v;
        orow = p / 32;
        ocol = p % 32;
        m = mem_a[c][(2 * orow) * 64 + 2 * ocol];
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = mem_a[c][(2 * orow + dy) * 64 + 2 * ocol + dx];
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic start_a();
        @(negedge clk) ready_a = 1'b1;
        @(negedge clk) ready_a = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk) ready_b = 1'b1;
        @(negedge clk) ready_b = 1'b0;
    endtask

    task automatic wait_idle_a(input int lim);
        int n = 0;
        while (busy_a && n < lim) begin @(negedge clk); n++; end
        check("timeout_a", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle_b(input int lim);
        int n = 0;
        while (busy_b && n < lim) begin @(negedge clk); n++; end
        check("timeout_b", 32'(busy_b), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_full_a(input string tag);
        int s_pool, s_flat, s_bad, bad0, bad1, badf;
        s_pool = wr_pool_a; s_flat = wr_flat_a; s_bad = wr_bad_a;
        start_a();
        wait_idle_a(JOB_A + 100);
        check({tag, "_busy_cycles"}, last_run_a, JOB_A);
        check({tag, "_pool_writes"}, wr_pool_a - s_pool, 2048);
        check({tag, "_flat_writes"}, wr_flat_a - s_flat, FL ? 2048 : 0);
        check({tag, "_bad_writes"}, wr_bad_a - s_bad, 0);
        bad0 = 0; bad1 = 0; badf = 0;
        for (int p = 0; p < 1024; p++) begin
            if (pooled_a[0][p] !== ref_a(0, p)) bad0++;
            if (pooled_a[1][p] !== ref_a(1, p)) bad1++;
            if (FL && flat_a[2 * p]     !== ref_a(0, p)) badf++;
            if (FL && flat_a[2 * p + 1] !== ref_a(1, p)) badf++;
        end
        check({tag, "_pool0_mismatches"}, bad0, 0);
        check({tag, "_pool1_mismatches"}, bad1, 0);
        check({tag, "_flat_mismatches"}, badf, 0);
    endtask

    vec_t tbl [8];

    initial begin
        int s_pool, s_flat, s_bad, s_starts, s_falls, n, ok;
        logic [11:0] i12;
        tbl[0] = '{20'hFFFFB, 20'hFFFFD, 20'hFFFF7, 20'hFFFFD, 20'hFFFFD};
        tbl[1] = '{20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00004};
        tbl[2] = '{20'h00009, 20'h00002, 20'h00003, 20'h00004, 20'h00009};
        tbl[3] = '{20'h7FFFF, 20'h80000, 20'h00000, 20'h00001, 20'h7FFFF};
        tbl[4] = '{20'h80000, 20'h80000, 20'h80000, 20'h80000, 20'h80000};
        tbl[5] = '{20'hFFFFF, 20'h00000, 20'hFFFFE, 20'hFFFFD, 20'h00000};
        tbl[6] = '{20'h00007, 20'h00007, 20'h00007, 20'h00007, 20'h00007};
        tbl[7] = '{20'hFFFFF, 20'h80001, 20'h80000, 20'hFFFFE, 20'hFFFFF};

        reset_a = 1'b1; reset_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_crd", 32'(crd_a), 0);
        check("rst_cwr", 32'(cwr_a), 0);
        check("rst_caddr_rd", 32'(caddr_rd_a), 0);
        check("rst_caddr_wr", 32'(caddr_wr_a), 0);
        check("rst_cdata_wr", 32'(cdata_wr_a), 0);
        check("rst_csel", 32'(csel_a), 0);
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp on channel 0, inverted ramp on channel 1.
        for (int i = 0; i < 4096; i++) begin
            i12 = 12'(i);
            mem_a[0][i] = {8'h00, i12};
            mem_a[1][i] = ~{8'h00, i12};
        end
        run_full_a("ramp");
        check("ramp_pool0_0", 32'(pooled_a[0][0]), 32'h00041);
        check("ramp_first_rd", 32'(first_addr_a), 0);
        if (FL) begin
            check("ramp_flat_0", 32'(flat_a[0]), 32'h00041);
            check("ramp_flat_1", 32'(flat_a[1]), 32'hFFFFF);
        end

        // Random maps with one all-negative window planted at pixel 5, channel 1.
        for (int i = 0; i < 4096; i++) begin
            mem_a[0][i] = 20'($urandom);
            mem_a[1][i] = 20'($urandom);
        end
        mem_a[1][10] = 20'hFFFFB; mem_a[1][11] = 20'hFFFFD;
        mem_a[1][74] = 20'hFFFF7; mem_a[1][75] = 20'hFFFFD;
        run_full_a("rand");
        check("neg_window", 32'(pooled_a[1][5]), 32'hFFFFD);
        check("overlap_a", overlap_a, 0);

        // Reset during the first read of pixel 10, channel 0.
        start_a();
        n = 0;
        while (!(crd_a && caddr_rd_a == 12'd20 && csel_a == 3'd1) && n < 2000) begin
            @(negedge clk); n++;
        end
        check("abort_reached_p10", 32'(n < 2000), 1);
        reset_a = 1'b1;
        @(posedge clk); #1;
        check("abort_crd", 32'(crd_a), 0);
        check("abort_cwr", 32'(cwr_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        @(negedge clk) reset_a = 1'b0;
        start_a();
        repeat (3) @(negedge clk);
        check("restart_first_rd", 32'(first_addr_a), 0);
        check("restart_first_sel", 32'(first_sel_a), 1);
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;

        // Table-driven windows on the 4x4 instance, four windows per job.
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 4; k++) begin
                int base;
                base = (2 * (k / 2)) * 4 + 2 * (k % 2);
                mem_b[base]     = tbl[g * 4 + k].a;
                mem_b[base + 1] = tbl[g * 4 + k].b;
                mem_b[base + 4] = tbl[g * 4 + k].c;
                mem_b[base + 5] = tbl[g * 4 + k].d;
            end
            s_pool = wr_pool_b; s_flat = wr_flat_b; s_bad = wr_bad_b;
            start_b();
            wait_idle_b(JOB_B + 50);
            check($sformatf("b%0d_busy_cycles", g), last_run_b, JOB_B);
            check($sformatf("b%0d_pool_writes", g), wr_pool_b - s_pool, 4);
            check($sformatf("b%0d_flat_writes", g), wr_flat_b - s_flat, FL ? 4 : 0);
            check($sformatf("b%0d_bad_writes", g), wr_bad_b - s_bad, 0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d_pool", g * 4 + k), 32'(pooled_b[k]), 32'(tbl[g * 4 + k].exp));
                if (FL) check($sformatf("vec%0d_flat", g * 4 + k), 32'(flat_b[k]), 32'(tbl[g * 4 + k].exp));
            end
        end

        // ready held high: back-to-back jobs separated by DONE and IDLE.
        s_starts = starts_b; s_falls = falls_b;
        @(negedge clk) ready_b = 1'b1;
        repeat (70) @(negedge clk);
        ready_b = 1'b0;
        wait_idle_b(JOB_B + 50);
        check("held_jobs_ge2", 32'(starts_b - s_starts >= 2), 1);
        ok = 1;
        for (int j = s_starts + 1; j < starts_b; j++)
            if (gaps_b[j % 64] != 2) ok = 0;
        check("held_gaps_eq2", ok, 1);
        ok = 1;
        for (int j = s_falls; j < falls_b; j++)
            if (runs_b[j % 64] != JOB_B) ok = 0;
        check("held_runs", ok, 1);
        check("overlap_b", overlap_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/pool_flat.md
POOL_FLAT -- requirements
Module: pool_flat

Interface
REQ-001 Parameter DW, default 20, data word width in bits (two's complement).
REQ-002 Parameter IMG_W, default 64, input map side length; power of two, 4..64.
REQ-003 Parameter CH, default 2, channel count, 1..3.
REQ-004 Parameter AW, default 12, address width; requires IMG_W*IMG_W <= 2^AW and (IMG_W/2)^2*CH <= 2^AW.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 ready  in  1  start request; sampled only in IDLE.
REQ-008 busy  out  1  high from accepted start until the job completes.
REQ-009 crd  out  1  layer-memory read strobe.
REQ-010 caddr_rd  out  AW  read address.
REQ-011 cdata_rd  in  DW  read data; valid at the rising edge one cycle after crd/caddr_rd/csel were driven.
REQ-012 cwr  out  1  layer-memory write strobe; cwr, caddr_wr and cdata_wr are sampled at the same rising edge.
REQ-013 caddr_wr  out  AW  write address.
REQ-014 cdata_wr  out  DW  write data.
REQ-015 csel  out  3  memory select: input channel c = 1+c; pooled channel c = 1+CH+c; flatten = 1+2*CH.

Function
REQ-016 The block SHALL perform 2x2 stride-2 max pooling on each of CH input maps (IMG_W x IMG_W, row-major).
REQ-017 Work order SHALL be output pixel p = orow*(IMG_W/2)+ocol (row-major) as the outer loop and channel 0..CH-1 as the inner loop.
REQ-018 FSM states SHALL be IDLE, RD, WAIT, WRP, WRF, DONE.
REQ-019 IDLE->RD on ready=1; busy SHALL rise on that same edge.
REQ-020 RD SHALL last 4 cycles with crd=1, issuing (dy,dx)=(0,0),(0,1),(1,0),(1,1) at caddr_rd=(2*orow+dy)*IMG_W+2*ocol+dx and csel=1+c.
REQ-021 WAIT SHALL last 1 cycle for the final read datum.
REQ-022 The running max SHALL load from the first datum and then keep the signed maximum of itself and each later datum; ties keep the stored value.
REQ-023 WRP SHALL drive cwr=1, csel=1+CH+c, caddr_wr=p and cdata_wr=max.
REQ-024 WRF (only with REQ-033) SHALL drive cwr=1, csel=1+2*CH, caddr_wr=p*CH+c and cdata_wr=max.
REQ-025 After a write, the FSM SHALL go to RD for the next (p,c), or to DONE after p=(IMG_W/2)^2-1 and c=CH-1.
REQ-026 DONE SHALL last 1 cycle with busy=0, then go to IDLE; ready held high in DONE SHALL NOT restart until IDLE samples it.
REQ-027 ready SHALL be ignored while busy=1.
REQ-028 crd and cwr SHALL never be high in the same cycle.
REQ-029 The cycle count per (p,c) SHALL be 6 without the feature and 7 with it; busy high time SHALL equal (IMG_W/2)^2*CH*(6 or 7) cycles.
REQ-030 Address counters SHALL produce no wrap-around within a job; all counters SHALL clear on entering DONE.

Reset
REQ-031 Reset SHALL force IDLE and set busy, crd and cwr to 0, caddr_rd, caddr_wr, cdata_wr and the max register to 0, and csel to 0.
REQ-032 Reset asserted mid-job SHALL abort the job at the next edge with no further strobes; the next job SHALL restart from p=0, c=0.

Configuration
REQ-033 Macro POOL_FLAT_FLATTEN_EN: when defined, WRF SHALL be present and the flatten output SHALL be written; when undefined, WRF SHALL be absent, WRP SHALL go directly to the next state, and csel=1+2*CH SHALL never be driven.

Structure
REQ-034 The shared package pool_flat_pkg SHALL hold the FSM state enum, the csel base constants and the address-width helper function.
REQ-035 One sub-module, pool_flat_max, SHALL hold the running signed-max register with load and update controls.
REQ-036 The remaining logic (FSM, address counters, strobes) SHALL reside in pool_flat.

Verification
REQ-037 Defaults, flatten on, input ch0 = ramp addr, ch1 = ~ramp: pooled ch0[0]=0x00041, flatten[0]=0x00041, flatten[1]=max of ch1 window {0,1,64,65}.
REQ-038 Negative window {-5,-3,-9,-3} (0xFFFFB, 0xFFFFD, 0xFFFF7, 0xFFFFD): written value SHALL be 0xFFFFD (signed compare).
REQ-039 IMG_W=4, CH=1, flatten off: busy SHALL be high for exactly 24 cycles, with 4 WRP writes at addresses 0..3 and no csel=3 write.
REQ-040 Reset pulsed in RD of pixel 10: crd and cwr SHALL be 0 on the next edge, busy=0; after restart, the first read SHALL be at address 0.
REQ-041 ready held high across the full job: exactly one job SHALL run per IDLE sampling, with busy low for at least 1 cycle (DONE) between jobs.
REQ-042 Full 64x64, CH=2, flatten on: 1024+1024 pooled words and 2048 flatten words SHALL match the golden data, with busy high for 14336 cycles.
